disparity_sad_engine: RTL and testbench
=======================================

Name: disparity_sad_engine

Overview:
- Second-generation stereo block-matching engine.
- Loads a left frame and then a right frame from the frame buffer over a valid/ready handshake into internal frame memories.
- For each output pixel, computes the sum of absolute differences (SAD) over a clamped window for every candidate disparity, and emits the arg-min disparity in raster order.
- Generalises the first-generation disparity FSM: pixel width, frame size, block size, search range and search direction are all parameters, and output is back-pressured.

Parameters:
- PIX_W, 8, pixel bit width.
- WIDTH, 46, frame width in pixels (≥2).
- HEIGHT, 30, frame height in pixels (≥1).
- HALF_BLOCK, 3, window half-size; window is (2*HALF_BLOCK+1)², clamped at frame edges.
- SEARCH_RANGE, 50, maximum disparity considered.
- SEARCH_DIR, 0, selects the right-frame column for candidate d: 0 = x+d, 1 = x−d.
- DISP_W, 6, output width; must satisfy 2^DISP_W > SEARCH_RANGE.

Ports:
- clk, input, 1, single clock; all logic rising-edge.
- reset, input, 1, synchronous, active-high.
- start, input, 1, one-cycle pulse; begins load+compute from IDLE, ignored otherwise.
- pix_valid, input, 1, buffer pixel valid.
- pix_data, input, PIX_W, buffer pixel, raster order.
- pix_ready, output, 1, engine accepts pixel; high only in LOAD_L/LOAD_R.
- image_sel, output, 1, 0 = left frame being loaded, 1 = right.
- disp_valid, output, 1, output disparity valid.
- disp_ready, input, 1, downstream accepts.
- disp_data, output, DISP_W, winning disparity.
- disp_eol, output, 1, qualifies disp_valid: last column of a row.
- disp_eof, output, 1, qualifies disp_valid: last pixel of frame.
- busy, output, 1, high in every state except IDLE.
- idle, output, 1, high in IDLE (LED).

Behaviour:
- Reset: state=IDLE; pix_ready, image_sel, disp_valid, disp_data, disp_eol, disp_eof, busy all 0; idle=1. Frame memories are not cleared. Reset mid-operation aborts immediately to IDLE; any partial output is discarded.
- States: IDLE → (start) LOAD_L → (WIDTH*HEIGHT pixels accepted) LOAD_R → (WIDTH*HEIGHT accepted) ACCUM ⇄ CMP → EMIT → ACCUM for the next pixel, or IDLE after the eof pixel.
- Load:
  - A pixel transfers on the cycle pix_valid&&pix_ready.
  - Address increments x then y.
  - image_sel goes to 1 on the cycle after the last left pixel transfers.
  - pix_ready stays 1 through both loads except in the cycle of the LOAD_L→LOAD_R transition, where it is 0.
  - pix_valid outside the load states is ignored.
- Window for output pixel (x,y):
  - Rows r0=max(0,y−H)..r1=min(HEIGHT−1,y+H).
  - Cols c0=max(0,x−H)..c1=min(WIDTH−1,x+H).
- Candidates: d=0..dmax.
  - dmax=min(SEARCH_RANGE, WIDTH−1−c1) for dir 0.
  - dmax=min(SEARCH_RANGE, c0) for dir 1.
  - d=0 is always a candidate.
- SAD(d) = Σ |L[r][c] − R[r][c±d]| over the window.
  - Unsigned, no saturation; accumulator width PIX_W + ceil(log2((2H+1)²)).
- ACCUM: one absolute difference per cycle (synchronous RAM reads; one-cycle pipeline fill allowed).
- CMP (1 cycle):
  - If d==0 or SAD<best, then best=SAD and best_d=d. Strict less-than, so ties keep the smallest d.
  - Next d → ACCUM; after dmax → EMIT.
- EMIT:
  - disp_valid=1 with disp_data=best_d, disp_eol=(x==WIDTH−1), disp_eof=(x==WIDTH−1 && y==HEIGHT−1).
  - All four signals hold stable until disp_ready; the transfer happens on valid&&ready.
  - disp_valid drops the cycle after the transfer.
  - disp_ready while not valid has no effect.
- Throughput bound per output pixel: ≤ (dmax+1)·(window_pixels+2)+2 cycles, excluding stall cycles.
- start while busy is ignored; start asserted in the same cycle as reset loses to reset.
- After the eof transfer: busy=0 and idle=1 on the next cycle. The next start reloads both frames.

Test Plan:
- WIDTH=8, HEIGHT=4, H=1, SEARCH_RANGE=3, dir 0; left and right both a unique ramp L=R=(17x+5y) mod 256 → 32 outputs, all disp 0; eol on x=7; eof only on the 32nd output.
- Same parameters; R[y][x]=L[y][x−2] with unique random texture → disp_data=2 wherever c1+2≤7; rightmost columns output ≤ their dmax.
- Flat frames (all 0x40) → every SAD equal, tie rule gives disp 0 for all 32 outputs.
- Run the shifted-by-2 case with SEARCH_DIR=1 and R[y][x]=L[y][x+2] → interior disp 2; column 0 gives 0 (dmax=0).
- Backpressure:
  - pix_valid toggling 1/0 and disp_ready low for 5 cycles on every third output → no pixel lost or duplicated.
  - disp_data, disp_eol and disp_eof stable while stalled.
  - Output sequence identical to the unstalled run.
- reset pulsed during ACCUM of pixel 10 → next cycle idle=1, disp_valid=0; a new start plus a reload reproduces the full correct 32-output sequence. start pulsed mid-LOAD_R is ignored (load count unaffected).

Source files
------------

// File: rtl/disparity_sad_engine_if.sv
// Frame-buffer load and disparity output signals of the stereo SAD engine.
// The master side drives the pixel stream and start; the slave side is the engine.
interface disparity_sad_engine_if #(
    parameter int PIX_W  = 8,
    parameter int DISP_W = 6
);
    logic              start;
    logic              pix_valid;
    logic [PIX_W-1:0]  pix_data;
    logic              pix_ready;
    logic              image_sel;
    logic              disp_valid;
    logic              disp_ready;
    logic [DISP_W-1:0] disp_data;
    logic              disp_eol;
    logic              disp_eof;
    logic              busy;
    logic              idle;

    modport master (
        output start, pix_valid, pix_data, disp_ready,
        input  pix_ready, image_sel, disp_valid, disp_data, disp_eol, disp_eof, busy, idle
    );

    modport slave (
        input  start, pix_valid, pix_data, disp_ready,
        output pix_ready, image_sel, disp_valid, disp_data, disp_eol, disp_eof, busy, idle
    );
endinterface

// File: rtl/disparity_sad_engine.sv
// Stereo block matcher: loads left then right frame, then emits the arg-min SAD
// disparity over a clamped window for every pixel in raster order.
module disparity_sad_engine #(
    parameter int PIX_W        = 8,
    parameter int WIDTH        = 46,
    parameter int HEIGHT       = 30,
    parameter int HALF_BLOCK   = 3,
    parameter int SEARCH_RANGE = 50,
    parameter int SEARCH_DIR   = 0,
    parameter int DISP_W       = 6
) (
    input logic                   clk,
    input logic                   reset,
    disparity_sad_engine_if.slave bus
);
    localparam int unsigned NPIX  = int'(WIDTH * HEIGHT);
    localparam int unsigned AW    = $clog2(NPIX);
    localparam int unsigned XW    = $clog2(WIDTH);
    localparam int unsigned YW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int unsigned WIN   = (2 * HALF_BLOCK + 1) * (2 * HALF_BLOCK + 1);
    localparam int unsigned ACC_W = PIX_W + $clog2(WIN);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_L, S_LOAD_R, S_ACCUM, S_CMP, S_EMIT
    } state_t;

    state_t            r_state;
    logic [AW-1:0]     r_load_addr;
    logic [XW-1:0]     r_x, r_wc;
    logic [YW-1:0]     r_y, r_wr;
    logic [DISP_W-1:0] r_d, r_best_d;
    logic [ACC_W-1:0]  r_sad, r_best;
    logic              r_init, r_issue_done, r_rd_vld;
    logic [PIX_W-1:0]  r_mem_l [NPIX];
    logic [PIX_W-1:0]  r_mem_r [NPIX];
    logic [PIX_W-1:0]  r_rd_l, r_rd_r;

    logic              r_pix_ready, r_image_sel, r_disp_valid, r_disp_eol, r_disp_eof;
    logic              r_busy, r_idle;
    logic [DISP_W-1:0] r_disp_data;

    int                w_r0, w_r1, w_c0, w_c1, w_dmax, w_rcol;
    logic [AW-1:0]     w_addr_l, w_addr_r;
    logic              w_xfer, w_last_col, w_last_row, w_last_d, w_better;
    logic [PIX_W-1:0]  w_absdiff;

    // Clamped window bounds and search limit for the current output pixel
    always_comb begin
        w_r0 = (int'(r_y) > HALF_BLOCK) ? int'(r_y) - HALF_BLOCK : 0;
        w_r1 = (int'(r_y) + HALF_BLOCK < HEIGHT) ? int'(r_y) + HALF_BLOCK : HEIGHT - 1;
        w_c0 = (int'(r_x) > HALF_BLOCK) ? int'(r_x) - HALF_BLOCK : 0;
        w_c1 = (int'(r_x) + HALF_BLOCK < WIDTH) ? int'(r_x) + HALF_BLOCK : WIDTH - 1;
        w_dmax = (SEARCH_DIR == 0) ? WIDTH - 1 - w_c1 : w_c0;
        if (w_dmax > SEARCH_RANGE) begin
            w_dmax = SEARCH_RANGE;
        end
        w_rcol     = (SEARCH_DIR == 0) ? int'(r_wc) + int'(r_d) : int'(r_wc) - int'(r_d);
        w_addr_l   = AW'(int'(r_wr) * WIDTH + int'(r_wc));
        w_addr_r   = AW'(int'(r_wr) * WIDTH + w_rcol);
        w_last_col = (int'(r_wc) == w_c1);
        w_last_row = (int'(r_wr) == w_r1);
        w_last_d   = (int'(r_d) == w_dmax);
        w_absdiff  = (r_rd_l >= r_rd_r) ? r_rd_l - r_rd_r : r_rd_r - r_rd_l;
        w_better   = (r_d == '0) || (r_sad < r_best);
        w_xfer     = bus.pix_valid && r_pix_ready;
    end

    // Frame memories: one write port from the loader, synchronous read for the window walk
    always_ff @(posedge clk) begin
        if (w_xfer && r_state == S_LOAD_L) begin
            r_mem_l[r_load_addr] <= bus.pix_data;
        end
        if (w_xfer && r_state == S_LOAD_R) begin
            r_mem_r[r_load_addr] <= bus.pix_data;
        end
        r_rd_l <= r_mem_l[w_addr_l];
        r_rd_r <= r_mem_r[w_addr_r];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_load_addr  <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_wc         <= '0;
            r_wr         <= '0;
            r_d          <= '0;
            r_best_d     <= '0;
            r_sad        <= '0;
            r_best       <= '0;
            r_init       <= 1'b0;
            r_issue_done <= 1'b0;
            r_rd_vld     <= 1'b0;
            r_pix_ready  <= 1'b0;
            r_image_sel  <= 1'b0;
            r_disp_valid <= 1'b0;
            r_disp_data  <= '0;
            r_disp_eol   <= 1'b0;
            r_disp_eof   <= 1'b0;
            r_busy       <= 1'b0;
            r_idle       <= 1'b1;
        end else begin
            r_rd_vld <= 1'b0;
            if (r_rd_vld) begin
                r_sad <= r_sad + ACC_W'(w_absdiff);
            end
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state     <= S_LOAD_L;
                        r_load_addr <= '0;
                        r_pix_ready <= 1'b1;
                        r_image_sel <= 1'b0;
                        r_busy      <= 1'b1;
                        r_idle      <= 1'b0;
                    end
                end
                S_LOAD_L: begin
                    if (w_xfer) begin
                        if (r_load_addr == AW'(NPIX - 1)) begin
                            r_load_addr <= '0;
                            r_state     <= S_LOAD_R;
                            r_image_sel <= 1'b1;
                            r_pix_ready <= 1'b0;
                        end else begin
                            r_load_addr <= r_load_addr + AW'(1);
                        end
                    end
                end
                S_LOAD_R: begin
                    r_pix_ready <= 1'b1;
                    if (w_xfer) begin
                        if (r_load_addr == AW'(NPIX - 1)) begin
                            r_load_addr <= '0;
                            r_state     <= S_ACCUM;
                            r_pix_ready <= 1'b0;
                            r_image_sel <= 1'b0;
                            r_init      <= 1'b1;
                            r_x         <= '0;
                            r_y         <= '0;
                        end else begin
                            r_load_addr <= r_load_addr + AW'(1);
                        end
                    end
                end
                // Walk the window issuing one read pair per cycle; last data lands one cycle later
                S_ACCUM: begin
                    if (r_init) begin
                        r_init       <= 1'b0;
                        r_wr         <= YW'(w_r0);
                        r_wc         <= XW'(w_c0);
                        r_d          <= '0;
                        r_sad        <= '0;
                        r_issue_done <= 1'b0;
                    end else if (!r_issue_done) begin
                        r_rd_vld <= 1'b1;
                        if (w_last_col) begin
                            r_wc <= XW'(w_c0);
                            if (w_last_row) begin
                                r_issue_done <= 1'b1;
                            end else begin
                                r_wr <= r_wr + YW'(1);
                            end
                        end else begin
                            r_wc <= r_wc + XW'(1);
                        end
                    end else begin
                        r_state <= S_CMP;
                    end
                end
                S_CMP: begin
                    if (w_better) begin
                        r_best   <= r_sad;
                        r_best_d <= r_d;
                    end
                    if (w_last_d) begin
                        r_state      <= S_EMIT;
                        r_disp_valid <= 1'b1;
                        r_disp_data  <= w_better ? r_d : r_best_d;
                        r_disp_eol   <= (r_x == XW'(WIDTH - 1));
                        r_disp_eof   <= (r_x == XW'(WIDTH - 1)) && (r_y == YW'(HEIGHT - 1));
                    end else begin
                        r_state      <= S_ACCUM;
                        r_d          <= r_d + DISP_W'(1);
                        r_wr         <= YW'(w_r0);
                        r_wc         <= XW'(w_c0);
                        r_sad        <= '0;
                        r_issue_done <= 1'b0;
                    end
                end
                S_EMIT: begin
                    if (bus.disp_ready) begin
                        r_disp_valid <= 1'b0;
                        r_disp_eol   <= 1'b0;
                        r_disp_eof   <= 1'b0;
                        if (r_disp_eof) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_idle  <= 1'b1;
                        end else begin
                            r_state <= S_ACCUM;
                            r_init  <= 1'b1;
                            if (r_x == XW'(WIDTH - 1)) begin
                                r_x <= '0;
                                r_y <= r_y + YW'(1);
                            end else begin
                                r_x <= r_x + XW'(1);
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.pix_ready  = r_pix_ready;
    assign bus.image_sel  = r_image_sel;
    assign bus.disp_valid = r_disp_valid;
    assign bus.disp_data  = r_disp_data;
    assign bus.disp_eol   = r_disp_eol;
    assign bus.disp_eof   = r_disp_eof;
    assign bus.busy       = r_busy;
    assign bus.idle       = r_idle;
endmodule

// File: tb/tb_disparity_sad_engine.sv
// Bench for disparity_sad_engine: one instance per search direction share the
// pixel stream; each output stream is checked against a direct SAD model.
module tb_disparity_sad_engine;
    localparam int PW = 8, DW = 6, W = 8, HT = 4, HB = 1, SR = 3, NPIX = W * HT;

    logic clk = 1'b0;
    logic reset, start, pix_valid, rdy0, rdy1;
    logic [PW-1:0] pix_data;
    always #5 clk = ~clk;

    disparity_sad_engine_if #(.PIX_W(PW), .DISP_W(DW)) if0 ();
    disparity_sad_engine_if #(.PIX_W(PW), .DISP_W(DW)) if1 ();

    assign if0.start = start;     assign if1.start = start;
    assign if0.pix_valid = pix_valid; assign if1.pix_valid = pix_valid;
    assign if0.pix_data = pix_data;   assign if1.pix_data = pix_data;
    assign if0.disp_ready = rdy0;     assign if1.disp_ready = rdy1;

    disparity_sad_engine #(.PIX_W(PW), .WIDTH(W), .HEIGHT(HT), .HALF_BLOCK(HB),
        .SEARCH_RANGE(SR), .SEARCH_DIR(0), .DISP_W(DW)) u_dut0 (.clk(clk), .reset(reset), .bus(if0));
    disparity_sad_engine #(.PIX_W(PW), .WIDTH(W), .HEIGHT(HT), .HALF_BLOCK(HB),
        .SEARCH_RANGE(SR), .SEARCH_DIR(1), .DISP_W(DW)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));

    int n_checks = 0, n_fail = 0;
    logic [7:0] lf [NPIX];
    logic [7:0] rf [NPIX];
    int e0 [NPIX];
    int e1 [NPIX];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic f_valid(input int s); return (s == 0) ? if0.disp_valid : if1.disp_valid; endfunction
    function automatic logic [DW-1:0] f_data(input int s); return (s == 0) ? if0.disp_data : if1.disp_data; endfunction
    function automatic logic f_eol(input int s); return (s == 0) ? if0.disp_eol : if1.disp_eol; endfunction
    function automatic logic f_eof(input int s); return (s == 0) ? if0.disp_eof : if1.disp_eof; endfunction
    function automatic logic f_busy(input int s); return (s == 0) ? if0.busy : if1.busy; endfunction
    function automatic logic f_idle(input int s); return (s == 0) ? if0.idle : if1.idle; endfunction

    task automatic set_rdy(input int s, input logic v);
        if (s == 0) rdy0 = v; else rdy1 = v;
    endtask

    // Exhaustive SAD over the clamped window for every allowed disparity
    function automatic int model_disp(input int x, input int y, input int dir);
        int r0, r1, c0, c1, dmax, best, bd, sad, a, b;
        r0 = (y > HB) ? y - HB : 0;
        r1 = (y + HB < HT) ? y + HB : HT - 1;
        c0 = (x > HB) ? x - HB : 0;
        c1 = (x + HB < W) ? x + HB : W - 1;
        dmax = (dir == 0) ? W - 1 - c1 : c0;
        if (dmax > SR) dmax = SR;
        best = 0;
        bd = 0;
        for (int d = 0; d <= dmax; d++) begin
            sad = 0;
            for (int r = r0; r <= r1; r++) begin
                for (int c = c0; c <= c1; c++) begin
                    a = int'(lf[r * W + c]);
                    b = int'(rf[r * W + ((dir == 0) ? c + d : c - d)]);
                    sad += (a > b) ? a - b : b - a;
                end
            end
            if (d == 0 || sad < best) begin
                best = sad;
                bd = d;
            end
        end
        return bd;
    endfunction

    task automatic compute_exp();
        for (int i = 0; i < NPIX; i++) begin
            e0[i] = model_disp(i % W, i / W, 0);
            e1[i] = model_disp(i % W, i / W, 1);
        end
    endtask

    task automatic do_load(input bit toggle, input bit start_mid);
        int idx = 0, cyc = 0;
        bit gap_seen = 0, pulsed = 0;
        while (idx < 2 * NPIX && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            start = start_mid && idx == NPIX + 5 && !pulsed;
            if (start) pulsed = 1;
            pix_valid = toggle ? (cyc % 2 == 1) : 1'b1;
            pix_data = (idx < NPIX) ? lf[idx] : rf[idx - NPIX];
            check("image_sel", 32'(if0.image_sel), 32'(idx >= NPIX));
            if (idx == NPIX && !gap_seen) begin
                check("pix_ready_gap", 32'(if0.pix_ready), 0);
                gap_seen = 1;
            end
            if (pix_valid && if0.pix_ready) idx++;
        end
        check("load_count", idx, 2 * NPIX);
        @(negedge clk);
        start = 0;
        pix_valid = 0;
        check("pix_ready_after_load", 32'(if0.pix_ready), 0);
    endtask

    task automatic collect(input int s, input bit stall, input int n_out);
        int k = 0, cyc = 0, d;
        bit eol, eof, prev_x = 0;
        set_rdy(s, 1'b1);
        while (k < n_out && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (prev_x) begin
                check($sformatf("d%0d_valid_drop", s), 32'(f_valid(s)), 0);
                prev_x = 0;
            end
            if (f_valid(s)) begin
                d = (s == 0) ? e0[k] : e1[k];
                eol = (k % W == W - 1);
                eof = (k == NPIX - 1);
                check($sformatf("d%0d_data[%0d]", s, k), 32'(f_data(s)), d);
                check($sformatf("d%0d_eol[%0d]", s, k), 32'(f_eol(s)), 32'(eol));
                check($sformatf("d%0d_eof[%0d]", s, k), 32'(f_eof(s)), 32'(eof));
                if (stall && k % 3 == 2) begin
                    set_rdy(s, 1'b0);
                    repeat (5) begin
                        @(negedge clk);
                        cyc++;
                        check($sformatf("d%0d_stall_valid", s), 32'(f_valid(s)), 1);
                        check($sformatf("d%0d_stall_data", s), 32'(f_data(s)), d);
                        check($sformatf("d%0d_stall_eol", s), 32'(f_eol(s)), 32'(eol));
                        check($sformatf("d%0d_stall_eof", s), 32'(f_eof(s)), 32'(eof));
                    end
                    set_rdy(s, 1'b1);
                end
                k++;
                prev_x = 1;
            end
        end
        check($sformatf("d%0d_out_count", s), k, n_out);
        if (n_out == NPIX) begin
            @(negedge clk);
            check($sformatf("d%0d_busy_end", s), 32'(f_busy(s)), 0);
            check($sformatf("d%0d_idle_end", s), 32'(f_idle(s)), 1);
            check($sformatf("d%0d_valid_end", s), 32'(f_valid(s)), 0);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        check("busy_after_start", 32'(if0.busy), 1);
        check("idle_after_start", 32'(if0.idle), 0);
        check("pix_ready_after_start", 32'(if0.pix_ready), 1);
        check("image_sel_after_start", 32'(if0.image_sel), 0);
    endtask

    task automatic run_test(input bit toggle, input bit stall, input bit start_mid);
        compute_exp();
        pulse_start();
        fork
            do_load(toggle, start_mid);
            collect(0, stall, NPIX);
            collect(1, stall, NPIX);
        join
    endtask

    initial begin
        reset = 1; start = 0; pix_valid = 0; pix_data = '0; rdy0 = 1; rdy1 = 1;
        repeat (3) @(negedge clk);
        start = 1;
        @(negedge clk);
        reset = 0;
        start = 0;
        for (int s = 0; s < 2; s++) begin
            check("rst_valid", 32'(f_valid(s)), 0);
            check("rst_data", 32'(f_data(s)), 0);
            check("rst_eol", 32'(f_eol(s)), 0);
            check("rst_eof", 32'(f_eof(s)), 0);
            check("rst_busy", 32'(f_busy(s)), 0);
            check("rst_idle", 32'(f_idle(s)), 1);
        end
        check("rst_pix_ready", 32'(if0.pix_ready), 0);
        check("rst_image_sel", 32'(if0.image_sel), 0);
        @(negedge clk);
        check("start_with_reset_lost", 32'(if0.idle), 1);

        // Unique ramp, identical frames
        for (int i = 0; i < NPIX; i++) begin
            lf[i] = 8'((17 * (i % W) + 5 * (i / W)) % 256);
            rf[i] = lf[i];
        end
        run_test(0, 0, 0);

        // Right frame shifted so that dir 0 matches at d=2
        for (int i = 0; i < NPIX; i++) lf[i] = 8'($urandom);
        for (int i = 0; i < NPIX; i++) rf[i] = (i % W >= 2) ? lf[i - 2] : 8'($urandom);
        run_test(1, 0, 0);

        // Same frames with output backpressure
        run_test(1, 1, 0);

        // Flat frames: all ties
        for (int i = 0; i < NPIX; i++) begin
            lf[i] = 8'h40;
            rf[i] = 8'h40;
        end
        run_test(0, 0, 0);

        // Right frame shifted so that dir 1 matches at d=2
        for (int i = 0; i < NPIX; i++) lf[i] = 8'($urandom);
        for (int i = 0; i < NPIX; i++) rf[i] = (i % W + 2 < W) ? lf[i + 2] : 8'($urandom);
        run_test(0, 0, 0);

        // Abort during pixel 10, then a full rerun with a stray start mid-load
        compute_exp();
        pulse_start();
        fork
            do_load(0, 0);
            collect(0, 0, 10);
        join
        @(negedge clk);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        for (int s = 0; s < 2; s++) begin
            check("abort_idle", 32'(f_idle(s)), 1);
            check("abort_valid", 32'(f_valid(s)), 0);
            check("abort_busy", 32'(f_busy(s)), 0);
        end
        run_test(0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
